// File: rtl/data_bus_responder.sv
// data_bus_responder
//   Responder end of the core's data-memory interface. The lower half of the
//   8-bit byte address space is word RAM. From MMIO_BASE upward sit the
//   peripheral registers: GPIO output, a compare/auto-reload timer with an
//   interrupt, and a free-running cycle counter. Reads are combinational.
//   Writes commit on the rising edge.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (RAM is not cleared)
//   w_en       write strobe
//   address    byte address; bits [1:0] ignored
//   wr_data    store data
//   rd_data    combinational read data for address
//   gpio_out   GPIO_OUT register
//   timer_irq  registered TCTRL.pend & TCTRL.ie
//
// Register map (offsets from MMIO_BASE)
//   +0x00 GPIO_OUT RW   +0x04 TCOUNT RW   +0x08 TCMP RW
//   +0x0C TCTRL {ie, pend(W1C), autoreload, en}   +0x10 CYCLE RO
//   everything else in the peripheral window reads 0
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 32,
  parameter logic [7:0]  MMIO_BASE = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic [7:0]  address,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam logic [5:0] MMIO_WORD = MMIO_BASE[7:2];

  typedef enum logic [2:0] {
    SEL_GPIO,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL,
    SEL_CYCLE,
    SEL_NONE
  } reg_sel_t;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] gpio_q;
  logic [31:0] tcount_q;
  logic [31:0] tcmp_q;
  logic        en_q;
  logic        autoreload_q;
  logic        pend_q;
  logic        ie_q;
  logic [31:0] cycle_q;
  logic        irq_q;

  logic        is_mmio;
  logic [4:0]  ram_idx;
  logic        ram_hit;
  logic [5:0]  mmio_word;
  reg_sel_t    sel;

  logic        match;
  logic        wr_tcount;
  logic        wr_tctrl;
  logic [31:0] tcount_next;
  logic        pend_next;
  logic        ie_next;

  // Byte-lane bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  always_comb begin
    is_mmio   = (address >= MMIO_BASE);
    ram_idx   = address[6:2];
    ram_hit   = !is_mmio && (32'(ram_idx) < RAM_WORDS);
    mmio_word = address[7:2] - MMIO_WORD;
    sel       = SEL_NONE;
    if (is_mmio) begin
      case (mmio_word)
        6'd0:    sel = SEL_GPIO;
        6'd1:    sel = SEL_TCOUNT;
        6'd2:    sel = SEL_TCMP;
        6'd3:    sel = SEL_TCTRL;
        6'd4:    sel = SEL_CYCLE;
        default: sel = SEL_NONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux (zero latency, returns pre-edge state)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (ram_hit) begin
      rd_data = ram[ram_idx];
    end else begin
      case (sel)
        SEL_GPIO:   rd_data = gpio_q;
        SEL_TCOUNT: rd_data = tcount_q;
        SEL_TCMP:   rd_data = tcmp_q;
        SEL_TCTRL:  rd_data = {28'd0, ie_q, pend_q, autoreload_q, en_q};
        SEL_CYCLE:  rd_data = cycle_q;
        default:    rd_data = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Timer next-state. Priorities: CPU write to TCOUNT beats count/reload;
  // a match setting pend beats a same-edge write-1-to-clear.
  // ---------------------------------------------------------------------
  always_comb begin
    wr_tcount = w_en && (sel == SEL_TCOUNT);
    wr_tctrl  = w_en && (sel == SEL_TCTRL);
    match     = en_q && (tcount_q == tcmp_q);

    tcount_next = tcount_q;
    if (en_q) begin
      tcount_next = (match && autoreload_q) ? '0 : tcount_q + 32'd1;
    end
    if (wr_tcount) begin
      tcount_next = wr_data;
    end

    pend_next = pend_q;
    if (wr_tctrl && wr_data[2]) begin
      pend_next = 1'b0;
    end
    if (match) begin
      pend_next = 1'b1;
    end

    ie_next = wr_tctrl ? wr_data[3] : ie_q;
  end

  // ---------------------------------------------------------------------
  // RAM (no reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_en && ram_hit) begin
      ram[ram_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Peripheral registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q       <= '0;
      tcount_q     <= '0;
      tcmp_q       <= '1;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      pend_q       <= 1'b0;
      ie_q         <= 1'b0;
      cycle_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      tcount_q <= tcount_next;
      pend_q   <= pend_next;
      ie_q     <= ie_next;
      // irq registers the post-edge pend/ie so it always equals pend & ie.
      irq_q    <= pend_next & ie_next;
      if (w_en && (sel == SEL_GPIO)) begin
        gpio_q <= wr_data;
      end
      if (w_en && (sel == SEL_TCMP)) begin
        tcmp_q <= wr_data;
      end
      if (wr_tctrl) begin
        en_q         <= wr_data[0];
        autoreload_q <= wr_data[1];
      end
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = irq_q;

endmodule
